if_fetch_stage: RTL and testbench

//   RV32IC instruction-fetch stage. Owns the PC, drives the byte address into the

---
 rtl/if_pkg.sv | 16 +
 rtl/rvc_align.sv | 35 +++
 rtl/if_fetch_stage.sv | 113 +++++++++++
 tb/tb_if_fetch_stage.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Package shared by the instruction-fetch stage.
// Holds the fetch FSM state type and the instruction constants that fetch
// must recognise (reset NOP, EBREAK and C.EBREAK).
package if_pkg;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
   localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;
   localparam logic [15:0] C_EBREAK     = 16'h9002;

endpackage

// File: rtl/rvc_align.sv
// Combinational instruction word alignment for RV32IC fetch.
// Ports:
//   imem_data   in   32  raw word from instruction memory
//   instr       out  32  32-bit instruction, or {16'h0, halfword} when compressed
//   compressed  out  1   low halfword is an RVC instruction
//   step        out  3   PC increment, 2 or 4
//   is_ebreak   out  1   instruction is EBREAK or C.EBREAK
module rvc_align
   import if_pkg::*;
#(
   parameter bit BIG_ENDIAN_IMEM = 1'b1
) (
   input  logic [31:0] imem_data,
   output logic [31:0] instr,
   output logic        compressed,
   output logic [2:0]  step,
   output logic        is_ebreak
);

   logic [31:0] w;

   always_comb begin
      // Byte-reverse big-endian memory so w[7:0] is the byte at the fetch address.
      if (BIG_ENDIAN_IMEM)
         w = {imem_data[7:0], imem_data[15:8], imem_data[23:16], imem_data[31:24]};
      else
         w = imem_data;

      compressed = (w[1:0] != 2'b11);
      step       = compressed ? 3'd2 : 3'd4;
      instr      = compressed ? {16'h0000, w[15:0]} : w;
      is_ebreak  = compressed ? (w[15:0] == C_EBREAK) : (w == EBREAK_INSTR);
   end

endmodule

// File: rtl/if_fetch_stage.sv
// RV32IC instruction-fetch stage: owns the PC, addresses the combinational
// instruction memory, and registers the aligned instruction into IF/ID.
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   stall              hold PC and IF/ID contents
//   redirect_valid     flush IF/ID and load redirect_pc (bit 0 cleared)
//   redirect_pc        redirect target
//   imem_addr          byte address into imem (low ADDR_W bits of PC)
//   imem_data          combinational word at imem_addr
//   if_valid           IF/ID holds a real instruction
//   if_pc              PC of the IF/ID instruction
//   if_instr           instruction (zero-extended halfword when compressed)
//   if_is_compressed   IF/ID instruction is RVC
//   if_pc_next         if_pc + 2 or + 4
//   halted             fetch stopped after EBREAK / C.EBREAK
module if_fetch_stage
   import if_pkg::*;
#(
   parameter logic [31:0] RESET_PC        = 32'h0000_0000,
   parameter int          ADDR_W          = 12,
   parameter bit          BIG_ENDIAN_IMEM = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_data,
   output logic              if_valid,
   output logic [31:0]       if_pc,
   output logic [31:0]       if_instr,
   output logic              if_is_compressed,
   output logic [31:0]       if_pc_next,
   output logic              halted
);

   state_t      state;
   logic [31:0] pc;
   logic [31:0] al_instr;
   logic        al_compressed;
   logic [2:0]  al_step;
   logic        al_is_ebreak;
   logic [31:0] pc_plus;
   logic [31:0] redirect_target;
   logic        unused_redirect_lsb;

   rvc_align #(
      .BIG_ENDIAN_IMEM(BIG_ENDIAN_IMEM)
   ) u_align (
      .imem_data (imem_data),
      .instr     (al_instr),
      .compressed(al_compressed),
      .step      (al_step),
      .is_ebreak (al_is_ebreak)
   );

   assign imem_addr           = pc[ADDR_W-1:0];
   assign pc_plus             = pc + {29'd0, al_step};
   assign redirect_target     = {redirect_pc[31:1], 1'b0};
   assign unused_redirect_lsb = redirect_pc[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= BOOT;
         pc               <= RESET_PC;
         if_valid         <= 1'b0;
         if_pc            <= RESET_PC;
         if_instr         <= NOP_INSTR;
         if_is_compressed <= 1'b0;
         if_pc_next       <= RESET_PC + 32'd4;
         halted           <= 1'b0;
      end else begin
         case (state)
            BOOT: begin
               if (!stall)
                  state <= RUN;
            end
            RUN: begin
               if (redirect_valid) begin
                  pc       <= redirect_target;
                  if_valid <= 1'b0;
               end else if (!stall) begin
                  if_valid         <= 1'b1;
                  if_pc            <= pc;
                  if_instr         <= al_instr;
                  if_is_compressed <= al_compressed;
                  if_pc_next       <= pc_plus;
                  // The breakpoint itself is delivered; the PC stays on it.
                  if (al_is_ebreak) begin
                     state  <= HALT;
                     halted <= 1'b1;
                  end else begin
                     pc <= pc_plus;
                  end
               end
            end
            HALT: begin
               if (redirect_valid) begin
                  pc       <= redirect_target;
                  if_valid <= 1'b0;
                  halted   <= 1'b0;
                  state    <= RUN;
               end else if (!stall) begin
                  if_valid <= 1'b0;
               end
            end
            default: state <= BOOT;
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [11:0] imem_addr;
   logic [31:0] imem_data;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_is_compressed;
   logic [31:0] if_pc_next;
   logic        halted;

   logic [7:0] mem [0:4095];
   int checks;
   int errors;

   if_fetch_stage #(
      .RESET_PC       (32'h0000_0000),
      .ADDR_W         (12),
      .BIG_ENDIAN_IMEM(1'b1)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .imem_addr       (imem_addr),
      .imem_data       (imem_data),
      .if_valid        (if_valid),
      .if_pc           (if_pc),
      .if_instr        (if_instr),
      .if_is_compressed(if_is_compressed),
      .if_pc_next      (if_pc_next),
      .halted          (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Big-endian memory: byte at the address lands in the top lane.
   always_comb begin
      logic [11:0] a1, a2, a3;
      a1 = imem_addr + 12'd1;
      a2 = imem_addr + 12'd2;
      a3 = imem_addr + 12'd3;
      imem_data = {mem[imem_addr], mem[a1], mem[a2], mem[a3]};
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic put_word(input int addr, input logic [31:0] w);
      mem[addr]   = w[7:0];
      mem[addr+1] = w[15:8];
      mem[addr+2] = w[23:16];
      mem[addr+3] = w[31:24];
   endtask

   task automatic put_half(input int addr, input logic [15:0] h);
      mem[addr]   = h[7:0];
      mem[addr+1] = h[15:8];
   endtask

   task automatic fill_nops();
      for (int i = 0; i < 4096; i += 4) put_word(i, 32'h0000_0013);
   endtask

   task automatic load_prog1();
      fill_nops();
      put_word(0, 32'h0010_0093);
      put_word(4, 32'h0010_8133);
      put_word(8, 32'h0000_2183);
   endtask

   task automatic apply_reset();
      rst            = 1'b1;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      load_prog1();
      apply_reset();
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", if_valid); end
      checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %08h exp 00000000", if_pc); end
      checks++; if (if_instr !== 32'h0000_0013) begin errors++; $display("FAIL reset_instr got %08h exp 00000013", if_instr); end
      checks++; if (if_is_compressed !== 1'b0) begin errors++; $display("FAIL reset_comp got %0h exp 0", if_is_compressed); end
      checks++; if (if_pc_next !== 32'h4) begin errors++; $display("FAIL reset_pc_next got %08h exp 00000004", if_pc_next); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %0h exp 0", halted); end
      checks++; if (imem_addr !== 12'h0) begin errors++; $display("FAIL reset_addr got %03h exp 000", imem_addr); end
   endtask

   task automatic test_straight_line();
      logic [31:0] exp_instr [3];
      exp_instr[0] = 32'h0010_0093;
      exp_instr[1] = 32'h0010_8133;
      exp_instr[2] = 32'h0000_2183;
      load_prog1();
      apply_reset();
      step();
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL boot_valid got %0h exp 0", if_valid); end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL sl_valid[%0d] got %0h exp 1", i, if_valid); end
         checks++; if (if_pc !== 32'(4*i)) begin errors++; $display("FAIL sl_pc[%0d] got %08h exp %08h", i, if_pc, 32'(4*i)); end
         checks++; if (if_pc_next !== 32'(4*i+4)) begin errors++; $display("FAIL sl_pc_next[%0d] got %08h exp %08h", i, if_pc_next, 32'(4*i+4)); end
         checks++; if (if_instr !== exp_instr[i]) begin errors++; $display("FAIL sl_instr[%0d] got %08h exp %08h", i, if_instr, exp_instr[i]); end
      end
   endtask

   task automatic test_mixed();
      logic [31:0] exp_pc [3];
      logic [31:0] exp_nx [3];
      logic [31:0] exp_in [3];
      logic        exp_c  [3];
      exp_pc[0] = 32'h0; exp_nx[0] = 32'h2; exp_in[0] = 32'h0000_4085; exp_c[0] = 1'b1;
      exp_pc[1] = 32'h2; exp_nx[1] = 32'h6; exp_in[1] = 32'h0010_0093; exp_c[1] = 1'b0;
      exp_pc[2] = 32'h6; exp_nx[2] = 32'h8; exp_in[2] = 32'h0000_0001; exp_c[2] = 1'b1;
      fill_nops();
      put_half(0, 16'h4085);
      put_word(2, 32'h0010_0093);
      put_half(6, 16'h0001);
      apply_reset();
      step();
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (if_pc !== exp_pc[i]) begin errors++; $display("FAIL mix_pc[%0d] got %08h exp %08h", i, if_pc, exp_pc[i]); end
         checks++; if (if_is_compressed !== exp_c[i]) begin errors++; $display("FAIL mix_comp[%0d] got %0h exp %0h", i, if_is_compressed, exp_c[i]); end
         checks++; if (if_instr !== exp_in[i]) begin errors++; $display("FAIL mix_instr[%0d] got %08h exp %08h", i, if_instr, exp_in[i]); end
         checks++; if (if_pc_next !== exp_nx[i]) begin errors++; $display("FAIL mix_pc_next[%0d] got %08h exp %08h", i, if_pc_next, exp_nx[i]); end
      end
   endtask

   task automatic test_stall();
      load_prog1();
      apply_reset();
      step(); step(); step();
      checks++; if (imem_addr !== 12'h8) begin errors++; $display("FAIL st_pre_addr got %03h exp 008", imem_addr); end
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (if_pc !== 32'h4) begin errors++; $display("FAIL st_pc[%0d] got %08h exp 00000004", i, if_pc); end
         checks++; if (if_instr !== 32'h0010_8133) begin errors++; $display("FAIL st_instr[%0d] got %08h exp 00108133", i, if_instr); end
         checks++; if (imem_addr !== 12'h8) begin errors++; $display("FAIL st_addr[%0d] got %03h exp 008", i, imem_addr); end
         checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL st_valid[%0d] got %0h exp 1", i, if_valid); end
      end
      stall = 1'b0;
      step();
      checks++; if (if_pc !== 32'h8) begin errors++; $display("FAIL st_resume_pc got %08h exp 00000008", if_pc); end
      checks++; if (if_instr !== 32'h0000_2183) begin errors++; $display("FAIL st_resume_instr got %08h exp 00002183", if_instr); end
   endtask

   task automatic test_redirect_over_stall();
      load_prog1();
      apply_reset();
      step(); step();
      stall          = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h41;
      step();
      stall          = 1'b0;
      redirect_valid = 1'b0;
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rd_valid got %0h exp 0", if_valid); end
      checks++; if (imem_addr !== 12'h040) begin errors++; $display("FAIL rd_addr got %03h exp 040", imem_addr); end
      step();
      checks++; if (if_pc !== 32'h40) begin errors++; $display("FAIL rd_pc got %08h exp 00000040", if_pc); end
      checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL rd_valid2 got %0h exp 1", if_valid); end
   endtask

   task automatic test_halt();
      bit found;
      fill_nops();
      put_word(32'h10, 32'h0010_0073);
      apply_reset();
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         if (if_valid === 1'b1 && if_pc === 32'h10) found = 1'b1;
      end
      checks++; if (!found) begin errors++; $display("FAIL halt_capture got timeout exp pc 00000010 valid"); end
      checks++; if (if_instr !== 32'h0010_0073) begin errors++; $display("FAIL halt_instr got %08h exp 00100073", if_instr); end
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag got %0h exp 1", halted); end
      step();
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL halt_valid got %0h exp 0", if_valid); end
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag2 got %0h exp 1", halted); end
      step();
      checks++; if (imem_addr !== 12'h010) begin errors++; $display("FAIL halt_addr got %03h exp 010", imem_addr); end
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0;
      step();
      redirect_valid = 1'b0;
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_clear got %0h exp 0", halted); end
      checks++; if (imem_addr !== 12'h000) begin errors++; $display("FAIL halt_redir_addr got %03h exp 000", imem_addr); end
      step();
      checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL halt_resume_valid got %0h exp 1", if_valid); end
      checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL halt_resume_pc got %08h exp 00000000", if_pc); end
   endtask

   task automatic test_reset_midstream();
      load_prog1();
      apply_reset();
      step(); step(); step();
      rst            = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h100;
      stall          = 1'b1;
      step();
      rst            = 1'b0;
      redirect_valid = 1'b0;
      stall          = 1'b0;
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid got %0h exp 0", if_valid); end
      checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL mrst_pc got %08h exp 00000000", if_pc); end
      checks++; if (if_instr !== 32'h0000_0013) begin errors++; $display("FAIL mrst_instr got %08h exp 00000013", if_instr); end
      checks++; if (if_pc_next !== 32'h4) begin errors++; $display("FAIL mrst_pc_next got %08h exp 00000004", if_pc_next); end
      checks++; if (imem_addr !== 12'h0) begin errors++; $display("FAIL mrst_addr got %03h exp 000", imem_addr); end
      step();
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL mrst_boot got %0h exp 0", if_valid); end
      step();
      checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL mrst_first_valid got %0h exp 1", if_valid); end
      checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL mrst_first_pc got %08h exp 00000000", if_pc); end
   endtask

   initial begin
      checks         = 0;
      errors         = 0;
      rst            = 1'b1;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      test_reset();
      test_straight_line();
      test_mixed();
      test_stall();
      test_redirect_over_stall();
      test_halt();
      test_reset_midstream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
